// File: rtl/i2c_reg_bank.sv
// Parametrised I2C register bank: pointer-load/auto-increment transactions, post-reset clear sweep, sticky error flag.
// Optional write protection above WP_BASE is enabled by defining I2C_REG_BANK_WRITE_PROTECT_EN.
module i2c_reg_bank #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DEPTH  = 128,
    parameter bit          WRAP   = 1'b1
`ifdef I2C_REG_BANK_WRITE_PROTECT_EN
    ,
    parameter int unsigned WP_BASE = DEPTH / 2
`endif
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              start_in,
    input  logic              dir_in,
    input  logic              stop_in,
    input  logic              wr_valid_in,
    input  logic [DATA_W-1:0] wr_data_in,
    input  logic              rd_req_in,
    output logic [DATA_W-1:0] rd_data_out,
    output logic              rd_valid_out,
    output logic [ADDR_W-1:0] ptr_out,
    output logic              busy_out,
    output logic              err_out
`ifdef I2C_REG_BANK_WRITE_PROTECT_EN
    ,
    input  logic              wp_in
`endif
);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_ADDR, S_WRITE, S_READ} state_t;

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                sat_q, sat_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic [ADDR_W:0]     ptr_inc;
    logic                at_last;
    logic [ADDR_W-1:0]   ptr_next;
    logic                sat_next;
    logic                access_ok;
    logic                wp_block;

    // ptr+1 reaching DEPTH means ptr sits on the last implemented location
    assign ptr_inc   = {1'b0, ptr_q} + 1'b1;
    assign at_last   = (ptr_inc == DEPTH_X);
    assign ptr_next  = at_last ? (WRAP ? '0 : ptr_q) : ptr_inc[ADDR_W-1:0];
    assign sat_next  = at_last && !WRAP;
    assign access_ok = ({1'b0, ptr_q} < DEPTH_X) && !sat_q;

`ifdef I2C_REG_BANK_WRITE_PROTECT_EN
    localparam logic [ADDR_W:0] WP_X = (ADDR_W + 1)'(WP_BASE);
    assign wp_block = wp_in && ({1'b0, ptr_q} >= WP_X);
`else
    assign wp_block = 1'b0;
`endif

    always_ff @(posedge clock_in) begin
        if (!reset_in) state_q <= S_INIT;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: begin
                if (cnt_q == LAST_CNT) state_d = S_IDLE;
            end
            default: begin
                if (start_in)                              state_d = dir_in ? S_READ : S_ADDR;
                else if (stop_in)                          state_d = S_IDLE;
                else if (state_q == S_ADDR && wr_valid_in) state_d = S_WRITE;
            end
        endcase
    end

    always_comb begin
        busy_out     = (state_q == S_INIT);
        err_out      = err_q;
        ptr_out      = ptr_q;
        rd_data_out  = rd_data_q;
        rd_valid_out = rd_valid_q;
    end

    // Datapath: protocol events (start over stop) pre-empt any data pulse in the same cycle.
    always_comb begin
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        err_d      = err_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = ptr_q;
        mem_wdata  = wr_data_in;
        if (state_q == S_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            cnt_d     = cnt_q + 1'b1;
            if (start_in || wr_valid_in || rd_req_in) err_d = 1'b1;
        end else if (start_in) begin
            err_d = 1'b0;
        end else if (!stop_in) begin
            case (state_q)
                S_ADDR: begin
                    if (wr_valid_in) begin
                        ptr_d = wr_data_in[ADDR_W-1:0];
                        sat_d = 1'b0;
                    end
                    if (rd_req_in) err_d = 1'b1;
                end
                S_WRITE: begin
                    if (wr_valid_in) begin
                        if (!access_ok) begin
                            err_d = 1'b1;
                        end else begin
                            if (wp_block) err_d  = 1'b1;
                            else          mem_we = 1'b1;
                            ptr_d = ptr_next;
                            sat_d = sat_next;
                        end
                    end
                    if (rd_req_in) err_d = 1'b1;
                end
                S_READ: begin
                    if (rd_req_in) begin
                        rd_valid_d = 1'b1;
                        if (access_ok) begin
                            rd_data_d = mem_q[ptr_q];
                            ptr_d     = ptr_next;
                            sat_d     = sat_next;
                        end else begin
                            rd_data_d = '0;
                            err_d     = 1'b1;
                        end
                    end
                    if (wr_valid_in) err_d = 1'b1;
                end
                default: begin
                    if (wr_valid_in || rd_req_in) err_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            ptr_q      <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in && mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

endmodule
